ysyx_041461_pipe_ctrl: RTL and testbench
========================================

# ysyx_041461_pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It produces the per-stage enable and bubble-insert (flush) signals for the PC, IF, ID, EXE, MEM and WB pipeline registers. It resolves traps, LSU stalls, load-use hazards, branch redirects and fetch stalls by fixed priority. A small state machine sequences multi-cycle LSU waits and post-trap drain.

## Interface
- `TRAP_CYCLES`, default 2: number of drain cycles spent in TRAP; legal range 1..15.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_busy`  in  1  fetch has no instruction ready this cycle.
- `mem_busy`  in  1  LSU transaction outstanding in MEM.
- `load_use`  in  1  ID instruction sources rd of a load currently in EXE.
- `br_taken`  in  1  EXE resolved a taken branch or jump.
- `wb_valid`  in  1  WB register holds a valid instruction.
- `wb_trap`  in  4  WB trap code; `ysyx_041461_TRAP_NOP` (4'd0) means no trap.
- `pc_enable`, `IFreg_enable`, `IDreg_enable`, `EXEreg_enable`, `MEMreg_enable`, `WBreg_enable`  out  1 each  register load enables.
- `IDreg_flush`, `EXEreg_flush`, `MEMreg_flush`, `WBreg_flush`  out  1 each  force `valid_in`=0 and trap/ctrl to NOP when the register loads.
- `redirect_sel`  out  2  00 sequential, 01 branch target, 10 trap vector.
- `lsu_kill`  out  1  abort the outstanding LSU transaction.
- `ctrl_state`  out  2  current FSM state.
- `perf_stall`, `perf_flush`  out  64 each  performance counters.

## Operation
- FSM states:
  - RUN=00
  - MEM_WAIT=01
  - TRAP=10
- Outputs are combinational from the state and the inputs. The state, the 4-bit drain counter and the perf counters are registers.
- A trap is `wb_valid && wb_trap != 0`.
- In RUN and MEM_WAIT, the first matching rule applies:
  1. Trap: `pc_enable`=1, `redirect_sel`=10, all reg enables=1, ID/EXE/MEM/WB flush=1, `lsu_kill`=`mem_busy`. Next state TRAP; counter loads `TRAP_CYCLES`-1.
  2. `mem_busy`: pc/IF/ID/EXE/MEM enables=0, `WBreg_enable`=1, `WBreg_flush`=1. Next state MEM_WAIT.
  3. `load_use`: pc/IF/ID enables=0, EXE/MEM/WB enables=1, `EXEreg_flush`=1.
  4. `br_taken`: all enables=1, `redirect_sel`=01, `IDreg_flush`=`EXEreg_flush`=1.
  5. `if_busy`: pc/IF enables=0, other enables=1, `IDreg_flush`=1.
  6. Otherwise: all enables=1, no flush, `redirect_sel`=00.
- Rules 3–6 return the FSM to RUN. MEM_WAIT exits in the first cycle `mem_busy`=0, and that cycle's outputs follow rules 3–6.
- TRAP:
  - Trap inputs are ignored.
  - pc/IF/ID/EXE/MEM enables=0, `WBreg_enable`=1, `WBreg_flush`=1, `redirect_sel`=00.
  - The counter decrements each cycle. When the counter is 0, the next state is RUN.
- Unflagged signals are 0: flushes, `lsu_kill`, and `redirect_sel`=00.

## Timing
- Zero-latency control. Enables and flushes take effect at the same `clk` edge as the triggering inputs.
- A trap seen at edge N puts the vector PC into the PC register at edge N. The pipeline stays frozen for exactly `TRAP_CYCLES` cycles, then fetch resumes.
- Trap and `mem_busy` at the same time: the trap wins and `lsu_kill`=1 for that single cycle.
- Reset (`rst_n`=0) behaviour, asynchronous:
  - State is RUN; counter and perf counters are 0.
  - While reset is asserted, all enables=0, all flushes=0, `redirect_sel`=00, `lsu_kill`=0, `ctrl_state`=00.
- Reset asserted in TRAP or MEM_WAIT aborts the sequence immediately. After release, the FSM starts in RUN.

## Configuration
- `YSYX_041461_PERF_EN` defined:
  - `perf_stall` increments every cycle with `pc_enable`=0 while out of reset.
  - `perf_flush` increments on every cycle that applies rule 1 or rule 4.
  - Both counters wrap modulo 2^64.
- Undefined: both ports are tied to 64'b0 and no counter flops are built.

## Test plan
- Idle pipeline, all inputs 0: all enables=1 and no flush every cycle; `ctrl_state`=00.
- `mem_busy` high for 3 cycles: MEM_WAIT for those 3 cycles with `WBreg_flush`=1. Normal enables resume in the cycle `mem_busy` falls.
- `wb_valid`=1, `wb_trap`=4'd3 with `TRAP_CYCLES`=2:
  - Trigger cycle: `redirect_sel`=10 and all four flushes=1.
  - Next 2 cycles: `ctrl_state`=10 with `pc_enable`=0.
  - Then RUN.
- Trap while `mem_busy`=1: `lsu_kill`=1 for exactly one cycle; next state TRAP, not MEM_WAIT.
- `load_use`=1 with `br_taken`=1: load-use wins, giving `pc_enable`=0, `EXEreg_flush`=1 and `redirect_sel`=00.
- With `YSYX_041461_PERF_EN`: one branch, then a 3-cycle `mem_busy` stall, gives `perf_flush`=1 and `perf_stall`=3. `rst_n` pulsed low mid-TRAP returns `ctrl_state` to 00 and the counters to 0.

Source files
------------

// File: rtl/ysyx_041461_pipe_ctrl.sv
`default_nettype none
// ysyx_041461_pipe_ctrl: priority stall/flush controller with MEM_WAIT/TRAP sequencing (rev 1.0)
// Optional perf counters: define YSYX_041461_PERF_EN.
module ysyx_041461_pipe_ctrl #(
  parameter int unsigned TRAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        load_use,
  input  logic        br_taken,
  input  logic        wb_valid,
  input  logic [3:0]  wb_trap,
  output logic        pc_enable,
  output logic        IFreg_enable,
  output logic        IDreg_enable,
  output logic        EXEreg_enable,
  output logic        MEMreg_enable,
  output logic        WBreg_enable,
  output logic        IDreg_flush,
  output logic        EXEreg_flush,
  output logic        MEMreg_flush,
  output logic        WBreg_flush,
  output logic [1:0]  redirect_sel,
  output logic        lsu_kill,
  output logic [1:0]  ctrl_state,
  output logic [63:0] perf_stall,
  output logic [63:0] perf_flush
);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_TRAP     = 2'b10
  } state_t;

  localparam logic [3:0] c_TRAP_NOP  = 4'd0;
  localparam logic [3:0] c_TRAP_LOAD = 4'(TRAP_CYCLES - 1);
  localparam logic [1:0] c_SEL_SEQ   = 2'b00;
  localparam logic [1:0] c_SEL_BR    = 2'b01;
  localparam logic [1:0] c_SEL_TRAP  = 2'b10;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_trap;

  assign w_trap     = wb_valid && (wb_trap != c_TRAP_NOP);
  assign ctrl_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    pc_enable     = 1'b0;
    IFreg_enable  = 1'b0;
    IDreg_enable  = 1'b0;
    EXEreg_enable = 1'b0;
    MEMreg_enable = 1'b0;
    WBreg_enable  = 1'b0;
    IDreg_flush   = 1'b0;
    EXEreg_flush  = 1'b0;
    MEMreg_flush  = 1'b0;
    WBreg_flush   = 1'b0;
    redirect_sel  = c_SEL_SEQ;
    lsu_kill      = 1'b0;
    // Everything stays quiet while reset is held, independent of the inputs.
    if (rst_n) begin
      if (r_state == S_TRAP) begin
        WBreg_enable = 1'b1;
        WBreg_flush  = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = S_RUN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end else if (w_trap) begin
        {pc_enable, IFreg_enable, IDreg_enable} = 3'b111;
        {EXEreg_enable, MEMreg_enable, WBreg_enable} = 3'b111;
        {IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush} = 4'b1111;
        redirect_sel = c_SEL_TRAP;
        lsu_kill     = mem_busy;
        w_state_nxt  = S_TRAP;
        w_cnt_nxt    = c_TRAP_LOAD;
      end else if (mem_busy) begin
        WBreg_enable = 1'b1;
        WBreg_flush  = 1'b1;
        w_state_nxt  = S_MEM_WAIT;
      end else begin
        w_state_nxt = S_RUN;
        {pc_enable, IFreg_enable, IDreg_enable} = 3'b111;
        {EXEreg_enable, MEMreg_enable, WBreg_enable} = 3'b111;
        if (load_use) begin
          {pc_enable, IFreg_enable, IDreg_enable} = 3'b000;
          EXEreg_flush = 1'b1;
        end else if (br_taken) begin
          redirect_sel = c_SEL_BR;
          IDreg_flush  = 1'b1;
          EXEreg_flush = 1'b1;
        end else if (if_busy) begin
          pc_enable    = 1'b0;
          IFreg_enable = 1'b0;
          IDreg_flush  = 1'b1;
        end
      end
    end
  end

`ifdef YSYX_041461_PERF_EN
  logic [63:0] r_perf_stall, r_perf_flush;

  // Only trap entry and branch redirect drive a non-sequential PC source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= 64'd0;
      r_perf_flush <= 64'd0;
    end else begin
      if (!pc_enable)                 r_perf_stall <= r_perf_stall + 64'd1;
      if (redirect_sel != c_SEL_SEQ)  r_perf_flush <= r_perf_flush + 64'd1;
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_flush = r_perf_flush;
`else
  assign perf_stall = 64'd0;
  assign perf_flush = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
`default_nettype none
// tb_ysyx_041461_pipe_ctrl: directed checks of priority, MEM_WAIT, TRAP drain, reset and perf counters.
module tb_ysyx_041461_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_busy, mem_busy, load_use, br_taken, wb_valid;
  logic [3:0]  wb_trap;
  logic        pc_enable, IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable;
  logic        IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush;
  logic [1:0]  redirect_sel, ctrl_state;
  logic        lsu_kill;
  logic [63:0] perf_stall, perf_flush;

  int n_pass  = 0;
  int n_total = 0;

`ifdef YSYX_041461_PERF_EN
  localparam bit c_PERF = 1'b1;
`else
  localparam bit c_PERF = 1'b0;
`endif

  ysyx_041461_pipe_ctrl #(.TRAP_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_busy(if_busy), .mem_busy(mem_busy), .load_use(load_use),
    .br_taken(br_taken), .wb_valid(wb_valid), .wb_trap(wb_trap),
    .pc_enable(pc_enable), .IFreg_enable(IFreg_enable), .IDreg_enable(IDreg_enable),
    .EXEreg_enable(EXEreg_enable), .MEMreg_enable(MEMreg_enable), .WBreg_enable(WBreg_enable),
    .IDreg_flush(IDreg_flush), .EXEreg_flush(EXEreg_flush),
    .MEMreg_flush(MEMreg_flush), .WBreg_flush(WBreg_flush),
    .redirect_sel(redirect_sel), .lsu_kill(lsu_kill), .ctrl_state(ctrl_state),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later, well before the next rising edge.
  task automatic drive(input logic ib, input logic mb, input logic lu, input logic br,
                       input logic wv, input logic [3:0] wt);
    @(negedge clk);
    if_busy = ib; mem_busy = mb; load_use = lu; br_taken = br; wb_valid = wv; wb_trap = wt;
    #1;
  endtask

  // en = {pc,IF,ID,EXE,MEM,WB}, fl = {ID,EXE,MEM,WB}
  task automatic expect_out(input string tag, input logic [5:0] en, input logic [3:0] fl,
                            input logic [1:0] rs, input logic kill, input logic [1:0] st);
    chk({tag, ".en"}, {58'd0, pc_enable, IFreg_enable, IDreg_enable,
                       EXEreg_enable, MEMreg_enable, WBreg_enable}, {58'd0, en});
    chk({tag, ".fl"}, {60'd0, IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush}, {60'd0, fl});
    chk({tag, ".rs"}, {62'd0, redirect_sel}, {62'd0, rs});
    chk({tag, ".kill"}, {63'd0, lsu_kill}, {63'd0, kill});
    chk({tag, ".st"}, {62'd0, ctrl_state}, {62'd0, st});
  endtask

  task automatic expect_perf(input string tag, input int stall, input int flush);
    chk({tag, ".pstall"}, perf_stall, c_PERF ? 64'(stall) : 64'd0);
    chk({tag, ".pflush"}, perf_flush, c_PERF ? 64'(flush) : 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    {if_busy, mem_busy, load_use, br_taken, wb_valid} = 5'b0;
    wb_trap = 4'd0;
    #12;
    expect_out("reset", 6'b000000, 4'b0000, 2'b00, 1'b0, 2'b00);
    expect_perf("reset", 0, 0);

    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("idle0", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("idle1", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);

    // One branch, then a 3-cycle LSU stall
    drive(0, 0, 0, 1, 0, 4'd0); expect_out("branch", 6'b111111, 4'b1100, 2'b01, 1'b0, 2'b00);
    drive(0, 1, 0, 0, 0, 4'd0); expect_out("mem0", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b00);
    drive(0, 1, 0, 0, 0, 4'd0); expect_out("mem1", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b01);
    drive(0, 1, 0, 0, 0, 4'd0); expect_out("mem2", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b01);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("memexit", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b01);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("memrun", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    expect_perf("br_mem", 3, 1);

    // Priority between simultaneous hazards
    drive(0, 0, 1, 1, 0, 4'd0); expect_out("lu_br", 6'b000111, 4'b0100, 2'b00, 1'b0, 2'b00);
    drive(1, 0, 0, 0, 0, 4'd0); expect_out("ifbusy", 6'b001111, 4'b1000, 2'b00, 1'b0, 2'b00);
    drive(1, 0, 0, 1, 0, 4'd0); expect_out("br_if", 6'b111111, 4'b1100, 2'b01, 1'b0, 2'b00);
    drive(0, 0, 0, 0, 1, 4'd0); expect_out("wbnop", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    drive(0, 0, 0, 0, 0, 4'd5); expect_out("trapnv", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    drive(1, 1, 1, 1, 0, 4'd0); expect_out("mem_all", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b00);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("mw_exit", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b01);
    // stalls so far: 3 + lu_br + ifbusy + mem_all = 6; flushes: 1 + br_if = 2
    expect_perf("prio", 6, 2);

    // Trap with TRAP_CYCLES=2; trap inputs held high in TRAP must be ignored
    drive(0, 0, 0, 0, 1, 4'd3); expect_out("trap", 6'b111111, 4'b1111, 2'b10, 1'b0, 2'b00);
    drive(0, 0, 0, 0, 1, 4'd3); expect_out("drain0", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b10);
    drive(0, 0, 1, 1, 1, 4'd3); expect_out("drain1", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b10);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("postrap", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    expect_perf("trap", 8, 3);

    // Trap during an LSU stall: kill for one cycle, enter TRAP
    drive(0, 1, 0, 0, 1, 4'd7); expect_out("trapmem", 6'b111111, 4'b1111, 2'b10, 1'b1, 2'b00);
    drive(0, 1, 0, 0, 0, 4'd0); expect_out("tm_drain0", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b10);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("tm_drain1", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b10);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("tm_run", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    expect_perf("trapmem", 10, 4);

    // Asynchronous reset mid-TRAP
    drive(0, 0, 0, 0, 1, 4'd1); expect_out("trap2", 6'b111111, 4'b1111, 2'b10, 1'b0, 2'b00);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("t2_drain", 6'b000001, 4'b0001, 2'b00, 1'b0, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    expect_out("rst_mid", 6'b000000, 4'b0000, 2'b00, 1'b0, 2'b00);
    expect_perf("rst_mid", 0, 0);
    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("after_rst", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    drive(0, 0, 0, 0, 0, 4'd0); expect_out("after_rst1", 6'b111111, 4'b0000, 2'b00, 1'b0, 2'b00);
    expect_perf("after_rst", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
